// File: rtl/prime_pkg.sv
// Shared definitions for the prime counter display path: widths, limits and
// the converter's state and digit types.
package prime_pkg;

    localparam int BIN_W      = 20;
    localparam int BCD_DIGITS = 6;
    localparam int BCD_MAX    = 999999;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import prime_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), one input bit per clock,
// with a valid/ready input handshake and a held, saturating BCD output.
module bin_to_bcd_seq
    import prime_pkg::*;
#(
    parameter int N    = BIN_W,
    parameter int D    = BCD_DIGITS,
    parameter int MAXV = BCD_MAX
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   bin_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    output logic [4*D-1:0] bcd_o,
    output logic           out_valid_o,
    output logic           ovf_o,
    output logic           busy_o
);

    localparam int             CNT_W    = $clog2(N + 1);
    localparam int             BCD_W    = 4 * D;
    localparam logic [N-1:0]   MAXV_BIN = N'(MAXV);

    function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] digits,
                                                  input logic             ovf);
        return ovf ? {D{4'h9}} : digits;
    endfunction

    state_e           state_q, state_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [BCD_W-1:0] digits_q, digits_d, digits_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             unused_carry;

    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (digits_q[4*g +: 4]),
            .digit_o (digits_adj[4*g +: 4])
        );
    end

    // Values above MAXV are saturated, so the top digit never needs a carry out.
    assign unused_carry = digits_adj[BCD_W-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE:        in_ready_o = 1'b1;
            SHIFT, DONE: busy_o     = 1'b1;
            default:     in_ready_o = 1'b0;
        endcase
    end

    always_comb begin
        shreg_d     = shreg_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        ovf_pend_d  = ovf_pend_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shreg_d    = bin_i;
                    digits_d   = '0;
                    cnt_d      = CNT_W'(N);
                    ovf_pend_d = (bin_i > MAXV_BIN);
                end
            end
            SHIFT: begin
                // Correct first, then shift the binary MSB into the units digit.
                {digits_d, shreg_d} = {digits_adj[BCD_W-2:0], shreg_q, 1'b0};
                cnt_d               = cnt_q - 1'b1;
            end
            DONE: begin
                bcd_d       = saturate(digits_q, ovf_pend_q);
                ovf_d       = ovf_pend_q;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q     <= '0;
            digits_q    <= '0;
            cnt_q       <= '0;
            ovf_pend_q  <= 1'b0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            ovf_pend_q  <= ovf_pend_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign ovf_o       = ovf_q;
    assign out_valid_o = out_valid_q;

endmodule
